// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M divide path: funct3 encodings, the
// divider FSM state type, the default data width and the fixed result
// constants used by the divide-by-zero and signed-overflow cases.
package rv32m_pkg;

    localparam int DEFAULT_XLEN = 32;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } div_state_t;

    localparam logic [DEFAULT_XLEN-1:0] DIV_BY_ZERO_Q = '1;
    localparam logic [DEFAULT_XLEN-1:0] INT_MIN       = {1'b1, {(DEFAULT_XLEN-1){1'b0}}};

endpackage

// File: rtl/rv32m_div_step.sv
// One radix-2 restoring division iteration, purely combinational.
// The partial remainder is widened by one bit so the shifted value can
// exceed XLEN bits without losing the carry before the compare.
module rv32m_div_step
    import rv32m_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] next_rem,
    output logic [XLEN-1:0] next_quo
);

    logic [XLEN:0] partial;
    logic [XLEN:0] diff;

    // Shift in the next dividend bit, then subtract the divisor if it fits.
    always_comb begin
        partial = {rem, quo[XLEN-1]};
        diff    = partial - {1'b0, divisor};
        if (partial >= {1'b0, divisor}) begin
            next_rem = diff[XLEN-1:0];
            next_quo = {quo[XLEN-2:0], 1'b1};
        end else begin
            next_rem = partial[XLEN-1:0];
            next_quo = {quo[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/rv32m_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow resolve in one cycle; all other
// operations take XLEN iterations plus one sign-fix cycle.
// Optional build macro RV32M_DIV_EARLY_OUT_EN: when defined, operations
// with |A| < |B| also resolve in one cycle (quotient 0, remainder A).
module rv32m_divider
    import rv32m_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] A_i,
    input  logic [XLEN-1:0] B_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] writeback_value_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  ALL_ONES  = '1;
    localparam logic [XLEN-1:0]  MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    // Two's-complement negate when the sign flag is set.
    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    div_state_t       state;
    logic [2:0]       funct3_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic             special_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  div_q;
    logic [CNT_W-1:0] cnt_q;

    logic            signed_op;
    logic            rem_op;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            special;
    logic [XLEN-1:0] special_val;
    logic [XLEN-1:0] next_rem;
    logic [XLEN-1:0] next_quo;
    logic            rem_op_q;
    logic [XLEN-1:0] final_val;

    // Decode the incoming request and resolve the one-cycle cases.
    always_comb begin
        signed_op   = (funct3_i == F3_DIV) || (funct3_i == F3_REM);
        rem_op      = (funct3_i == F3_REM) || (funct3_i == F3_REMU);
        a_neg       = signed_op && A_i[XLEN-1];
        b_neg       = signed_op && B_i[XLEN-1];
        abs_a       = neg_if(A_i, a_neg);
        abs_b       = neg_if(B_i, b_neg);
        special     = 1'b0;
        special_val = '0;
        if (B_i == '0) begin
            special     = 1'b1;
            special_val = rem_op ? A_i : ALL_ONES;
        end else if (signed_op && (A_i == MOST_NEG) && (B_i == ALL_ONES)) begin
            special     = 1'b1;
            special_val = rem_op ? '0 : MOST_NEG;
        end
`ifdef RV32M_DIV_EARLY_OUT_EN
        else if (abs_a < abs_b) begin
            special     = 1'b1;
            special_val = rem_op ? A_i : '0;
        end
`endif
    end

    rv32m_div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (div_q),
        .next_rem (next_rem),
        .next_quo (next_quo)
    );

    // Select the signed-corrected result, or the preloaded special value.
    always_comb begin
        rem_op_q = (funct3_q == F3_REM) || (funct3_q == F3_REMU);
        if (special_q) begin
            final_val = quo_q;
        end else if (rem_op_q) begin
            final_val = neg_if(rem_q, r_neg_q);
        end else begin
            final_val = neg_if(quo_q, q_neg_q);
        end
    end

    assign busy_o = (state != IDLE);

    // Divider FSM: accept, iterate, then register the result with a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            funct3_q          <= '0;
            q_neg_q           <= 1'b0;
            r_neg_q           <= 1'b0;
            special_q         <= 1'b0;
            rem_q             <= '0;
            quo_q             <= '0;
            div_q             <= '0;
            cnt_q             <= '0;
            done_o            <= 1'b0;
            writeback_value_o <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        funct3_q  <= funct3_i;
                        q_neg_q   <= a_neg ^ b_neg;
                        r_neg_q   <= a_neg;
                        special_q <= special;
                        div_q     <= abs_b;
                        rem_q     <= '0;
                        quo_q     <= special ? special_val : abs_a;
                        cnt_q     <= '0;
                        state     <= special ? FINISH : CALC;
                    end
                end
                CALC: begin
                    rem_q <= next_rem;
                    quo_q <= next_quo;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    writeback_value_o <= final_val;
                    done_o            <= 1'b1;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32m_divider.sv
// Directed testbench for rv32m_divider: result values, latency, busy/done
// handshake, ignored start while busy, back-to-back start and async reset.
module tb_rv32m_divider;
    import rv32m_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] A_i;
    logic [31:0] B_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] writeback_value_o;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    rv32m_divider #(.XLEN(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .start_i           (start_i),
        .funct3_i          (funct3_i),
        .A_i               (A_i),
        .B_i               (B_i),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .writeback_value_o (writeback_value_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle, then scramble the operands.
    task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        funct3_i = f3;
        A_i      = a;
        B_i      = b;
        start_i  = 1'b1;
        @(posedge clk);
        #1;
        start_i  = 1'b0;
        A_i      = $urandom;
        B_i      = $urandom;
        funct3_i = 3'b100;
    endtask

    // Wait (bounded) for done_o; check latency from accept, value and busy.
    task automatic wait_done(input string tag, input int start_cyc, input int lat,
                             input logic [31:0] exp);
        int c;
        c = start_cyc;
        while (!done_o && c < 60) begin
            @(posedge clk);
            #1;
            c++;
        end
        check({tag, "_done"}, 32'(done_o), 32'd1);
        check({tag, "_lat"}, 32'(c), 32'(lat));
        check({tag, "_val"}, writeback_value_o, exp);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start_i  = 1'b0;
        funct3_i = 3'b000;
        A_i      = '0;
        B_i      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_done", 32'(done_o), 32'd0);
        check("reset_wb", writeback_value_o, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        start_op(F3_DIVU, 32'h00000064, 32'h00000007);
        check("divu_busy_after_accept", 32'(busy_o), 32'd1);
        wait_done("divu_100_7", 0, 33, 32'h0000000E);
        start_op(F3_REMU, 32'h00000064, 32'h00000007);
        wait_done("remu_100_7", 0, 33, 32'h00000002);

        start_op(F3_DIV, 32'hFFFFFF9C, 32'h00000007);
        wait_done("div_m100_7", 0, 33, 32'hFFFFFFF2);
        start_op(F3_REM, 32'hFFFFFF9C, 32'h00000007);
        wait_done("rem_m100_7", 0, 33, 32'hFFFFFFFE);
        start_op(F3_DIVU, 32'h80000000, 32'h00000002);
        wait_done("divu_min_2", 0, 33, 32'h40000000);
        start_op(F3_DIV, 32'h80000000, 32'h00000002);
        wait_done("div_min_2", 0, 33, 32'hC0000000);
        start_op(F3_REM, 32'h00000007, 32'hFFFFFFFE);
        wait_done("rem_7_m2", 0, 33, 32'h00000001);

        start_op(F3_DIVU, 32'h12345678, 32'h00000000);
        wait_done("divu_by0", 0, 1, 32'hFFFFFFFF);
        start_op(F3_REMU, 32'h12345678, 32'h00000000);
        wait_done("remu_by0", 0, 1, 32'h12345678);
        start_op(F3_DIV, 32'h12345678, 32'h00000000);
        wait_done("div_by0", 0, 1, 32'hFFFFFFFF);
        start_op(F3_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done("div_ovf", 0, 1, 32'h80000000);
        start_op(F3_REM, 32'h80000000, 32'hFFFFFFFF);
        wait_done("rem_ovf", 0, 1, 32'h00000000);

        // A start while busy is ignored; a start in the done cycle is taken.
        start_op(F3_DIVU, 32'h00000064, 32'h00000007);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        funct3_i = F3_DIVU;
        A_i      = 32'h00000001;
        B_i      = 32'h00000001;
        start_i  = 1'b1;
        @(posedge clk);
        #1;
        start_i  = 1'b0;
        check("ignored_start_busy", 32'(busy_o), 32'd1);
        wait_done("divu_ignored", 5, 33, 32'h0000000E);
        start_op(F3_DIVU, 32'h00000064, 32'h0000000A);
        check("b2b_busy", 32'(busy_o), 32'd1);
        check("b2b_done_low", 32'(done_o), 32'd0);
        wait_done("divu_b2b", 0, 33, 32'h0000000A);

        // Asynchronous reset in the middle of an iteration.
        start_op(F3_DIVU, 32'h00000064, 32'h00000007);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_busy", 32'(busy_o), 32'd0);
        check("rst_mid_done", 32'(done_o), 32'd0);
        check("rst_mid_wb", writeback_value_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_idle", 32'(busy_o), 32'd0);
        start_op(F3_DIVU, 32'h00000009, 32'h00000002);
        wait_done("divu_after_rst", 0, 33, 32'h00000004);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
